// File: rtl/mmc_cmd_pkg.sv
// Shared MMC CMD-line definitions: FSM states, token geometry, CRC7 polynomial.
// Used by both the command serialiser and the response deserialiser.
package mmc_cmd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CMD     = 3'd1,
      ST_CRC     = 3'd2,
      ST_END     = 3'd3,
      ST_STOP    = 3'd4,
      ST_DONE    = 3'd5,
      ST_TRAILER = 3'd6
   } cmd_state_e;

   localparam int         CMD_TOKEN_W   = 48;
   localparam int         CMD_PAYLOAD_W = 40;
   localparam logic [6:0] CRC7_POLY     = 7'h09;

endpackage

// File: rtl/mmc_crc7.sv
// Single-bit CRC7 step (x^7 + x^3 + 1), shared by the CMD transmitter
// and the response receiver.
module mmc_crc7
   import mmc_cmd_pkg::*;
(
   input  logic [6:0] crc_i,
   input  logic       bit_i,
   output logic [6:0] crc_o
);

   logic fb;

   assign fb    = bit_i ^ crc_i[6];
   assign crc_o = {crc_i[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);

endmodule

// File: rtl/mmc_cmd_serialiser.sv
// Host MMC/SD CMD-line transmitter: start, dir, index, argument, CRC7, end bit.
// Optional Ncc/Nrc '1' padding after the end bit with MMC_CMD_SER_TRAILER_EN.
module mmc_cmd_serialiser
   import mmc_cmd_pkg::*;
#(
   parameter int TRAILER_BITS = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        bitclk_i,
   input  logic        start_i,
   input  logic        abort_i,
   input  logic [5:0]  cmd_i,
   input  logic [31:0] arg_i,
   output logic        data_o,
   output logic        data_oe_o,
   output logic        active_o,
   output logic        complete_o
);

   cmd_state_e               state_q;
   cmd_state_e               state_d;
   logic                     clk_q;
   logic                     drive_w;
   logic [CMD_PAYLOAD_W-1:0] shift_q;
   logic [6:0]               crc_q;
   logic [6:0]               crc_nx;
   logic [5:0]               idx_q;
`ifdef MMC_CMD_SER_TRAILER_EN
   logic [7:0]               trl_q;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) clk_q <= 1'b0;
      else       clk_q <= bitclk_i;
   end

   assign drive_w = ~bitclk_i & clk_q;

   mmc_crc7 u_crc7 (
      .crc_i (crc_q),
      .bit_i (shift_q[CMD_PAYLOAD_W-1]),
      .crc_o (crc_nx)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start_i) state_d = ST_CMD;
            ST_CMD:  if (drive_w && idx_q == 6'd0) state_d = ST_CRC;
            ST_CRC:  if (drive_w && idx_q == 6'd0) state_d = ST_END;
            ST_END:  if (drive_w) state_d = ST_STOP;
`ifdef MMC_CMD_SER_TRAILER_EN
            ST_STOP:    if (drive_w) state_d = ST_TRAILER;
            ST_TRAILER: if (drive_w && trl_q == 8'd0) state_d = ST_DONE;
`else
            ST_STOP:    if (drive_w) state_d = ST_DONE;
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      active_o   = (state_q != ST_IDLE);
      complete_o = (state_q == ST_DONE) && !abort_i;
   end

   // Datapath: every bit change is qualified by the bitclk falling edge.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_o    <= 1'b1;
         data_oe_o <= 1'b0;
         shift_q   <= '0;
         crc_q     <= '0;
         idx_q     <= '0;
`ifdef MMC_CMD_SER_TRAILER_EN
         trl_q     <= '0;
`endif
      end else if (abort_i) begin
         data_o    <= 1'b1;
         data_oe_o <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: if (start_i) begin
               shift_q <= {1'b0, 1'b1, cmd_i, arg_i};
               crc_q   <= '0;
               idx_q   <= 6'd39;
            end
            ST_CMD: if (drive_w) begin
               data_o    <= shift_q[CMD_PAYLOAD_W-1];
               data_oe_o <= 1'b1;
               shift_q   <= shift_q << 1;
               crc_q     <= crc_nx;
               idx_q     <= (idx_q == 6'd0) ? 6'd6 : idx_q - 6'd1;
            end
            ST_CRC: if (drive_w) begin
               data_o <= crc_q[6];
               crc_q  <= crc_q << 1;
               idx_q  <= idx_q - 6'd1;
            end
            ST_END: if (drive_w) data_o <= 1'b1;
`ifdef MMC_CMD_SER_TRAILER_EN
            ST_STOP:    if (drive_w) trl_q <= 8'(TRAILER_BITS - 1);
            ST_TRAILER: if (drive_w) trl_q <= trl_q - 8'd1;
`endif
            ST_DONE: begin
               data_o    <= 1'b1;
               data_oe_o <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mmc_cmd_serialiser.sv
// Self-checking bench for mmc_cmd_serialiser: randomized commands against
// a polynomial-division CRC7 token model; honours MMC_CMD_SER_TRAILER_EN.
module tb_mmc_cmd_serialiser;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bitclk = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [5:0]  cmd = '0;
   logic [31:0] arg = '0;
   logic        data;
   logic        oe;
   logic        active;
   logic        complete;

`ifdef MMC_CMD_SER_TRAILER_EN
   localparam int NBITS = 56;
`else
   localparam int NBITS = 48;
`endif

   int n_pass = 0;
   int n_total = 0;

   mmc_cmd_serialiser dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .bitclk_i   (bitclk),
      .start_i    (start),
      .abort_i    (abort),
      .cmd_i      (cmd),
      .arg_i      (arg),
      .data_o     (data),
      .data_oe_o  (oe),
      .active_o   (active),
      .complete_o (complete)
   );

   always #5 clk = ~clk;

   // Card bit clock: toggles every 'half' system clocks while running.
   int half = 3;
   bit bc_run = 1'b1;
   int bc_cnt = 0;
   always @(negedge clk) begin
      if (bc_run) begin
         bc_cnt++;
         if (bc_cnt >= half) begin
            bc_cnt = 0;
            bitclk = ~bitclk;
         end
      end
   end

   // Card-side view: sample the line on bitclk rising edges while driven.
   logic bits[$];
   int   n_cmpl = 0;
   int   size_at_cmpl = -1;
   always @(posedge bitclk) if (oe === 1'b1) bits.push_back(data);
   always @(negedge clk) begin
      if (complete === 1'b1) begin
         n_cmpl++;
         size_at_cmpl = bits.size();
      end
   end

   function automatic logic [6:0] ref_crc(input logic [39:0] m);
      logic [46:0] r;
      r = {m, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [47:0] ref_token(input logic [5:0] c,
                                             input logic [31:0] a);
      logic [39:0] m;
      m = {2'b01, c, a};
      return {m, ref_crc(m), 1'b1};
   endfunction

   function automatic logic [47:0] got_token();
      logic [47:0] t;
      t = '0;
      for (int i = 0; i < 48; i++)
         t = {t[46:0], (i < bits.size()) ? bits[i] : 1'bx};
      return t;
   endfunction

   task automatic launch(input logic [5:0] c, input logic [31:0] a);
      bits.delete();
      n_cmpl = 0;
      size_at_cmpl = -1;
      @(negedge clk);
      cmd = c;
      arg = a;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output bit to);
      to = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (n_cmpl > 0) begin
            to = 1'b0;
            break;
         end
      end
      repeat (4 * half + 4) @(negedge clk);
   endtask

   task automatic wait_bits(input int n, output bit to);
      to = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         if (bits.size() >= n) begin
            to = 1'b0;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_total++;
      if ({data, oe, active, complete} !== 4'b1000)
         $display("FAIL reset_hold: got %b want 1000",
                  {data, oe, active, complete});
      else n_pass++;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      n_total++;
      if ({data, oe, active, complete} !== 4'b1000)
         $display("FAIL reset_idle: got %b want 1000",
                  {data, oe, active, complete});
      else n_pass++;
   endtask

   task automatic test_known();
      logic [5:0]  cs [3] = '{6'd0, 6'd8, 6'd17};
      logic [31:0] as [3] = '{32'h0, 32'h1AA, 32'h0};
      logic [47:0] gs [3] = '{48'h40_0000_0000_95, 48'h48_0000_01AA_87,
                              48'h51_0000_0000_55};
      bit to;
      for (int k = 0; k < 3; k++) begin
         launch(cs[k], as[k]);
         n_total++;
         if (active !== 1'b1)
            $display("FAIL known_active%0d: got %b want 1", k, active);
         else n_pass++;
         wait_done(to);
         n_total++;
         if (to !== 1'b0 || got_token() !== gs[k])
            $display("FAIL known_token%0d: got %h want %h (timeout %0d)",
                     k, got_token(), gs[k], to);
         else n_pass++;
         n_total++;
         if (n_cmpl !== 1)
            $display("FAIL known_cmpl%0d: got %0d pulses want 1", k, n_cmpl);
         else n_pass++;
         n_total++;
         if (size_at_cmpl !== NBITS)
            $display("FAIL known_len%0d: got %0d bits want %0d",
                     k, size_at_cmpl, NBITS);
         else n_pass++;
`ifdef MMC_CMD_SER_TRAILER_EN
         begin
            bit ok;
            ok = (bits.size() == NBITS);
            for (int i = 48; i < bits.size(); i++) if (bits[i] !== 1'b1) ok = 0;
            n_total++;
            if (!ok)
               $display("FAIL known_trailer%0d: got %0d bits, not all 1",
                        k, bits.size());
            else n_pass++;
         end
`endif
      end
   endtask

   task automatic test_random();
      bit          to;
      logic [5:0]  c;
      logic [31:0] a;
      for (int k = 0; k < 6; k++) begin
         half = $urandom_range(2, 4);
         c = 6'($urandom);
         a = $urandom;
         launch(c, a);
         wait_done(to);
         n_total++;
         if (to !== 1'b0 || got_token() !== ref_token(c, a))
            $display("FAIL rand_token%0d: got %h want %h", k, got_token(),
                     ref_token(c, a));
         else n_pass++;
         n_total++;
         if (n_cmpl !== 1 || size_at_cmpl !== NBITS)
            $display("FAIL rand_cmpl%0d: got %0d pulses/%0d bits want 1/%0d",
                     k, n_cmpl, size_at_cmpl, NBITS);
         else n_pass++;
      end
      half = 3;
   endtask

   task automatic test_restart_ignored();
      bit          to;
      logic [31:0] a;
      a = $urandom;
      launch(6'd17, a);
      wait_bits(20, to);
      @(negedge clk);
      cmd = 6'd55;
      arg = ~a;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(to);
      n_total++;
      if (to !== 1'b0 || got_token() !== ref_token(6'd17, a))
         $display("FAIL restart_token: got %h want %h", got_token(),
                  ref_token(6'd17, a));
      else n_pass++;
      n_total++;
      if (n_cmpl !== 1)
         $display("FAIL restart_cmpl: got %0d pulses want 1", n_cmpl);
      else n_pass++;
   endtask

   task automatic test_abort();
      bit to;
      launch(6'($urandom), $urandom);
      wait_bits(30, to);
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      n_total++;
      if (to !== 1'b0 || {data, oe, active, complete} !== 4'b1000)
         $display("FAIL abort_outputs: got %b want 1000",
                  {data, oe, active, complete});
      else n_pass++;
      repeat (400) @(negedge clk);
      n_total++;
      if (n_cmpl !== 0)
         $display("FAIL abort_nocmpl: got %0d pulses want 0", n_cmpl);
      else n_pass++;
      launch(6'd0, 32'h0);
      wait_done(to);
      n_total++;
      if (to !== 1'b0 || got_token() !== 48'h40_0000_0000_95)
         $display("FAIL abort_next: got %h want 400000000095", got_token());
      else n_pass++;
      n_total++;
      if (n_cmpl !== 1)
         $display("FAIL abort_next_cmpl: got %0d pulses want 1", n_cmpl);
      else n_pass++;
   endtask

   task automatic test_abort_start_idle();
      bit quiet;
      bits.delete();
      n_cmpl = 0;
      @(negedge clk);
      cmd = 6'd8;
      arg = $urandom;
      start = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      n_total++;
      if (active !== 1'b0)
         $display("FAIL abstart_active: got %b want 0", active);
      else n_pass++;
      quiet = 1'b1;
      repeat (200) begin
         @(negedge clk);
         if (oe !== 1'b0 || active !== 1'b0) quiet = 1'b0;
      end
      n_total++;
      if (!quiet || bits.size() != 0)
         $display("FAIL abstart_quiet: got %0d bits want 0", bits.size());
      else n_pass++;
      n_total++;
      if (n_cmpl !== 0)
         $display("FAIL abstart_cmpl: got %0d pulses want 0", n_cmpl);
      else n_pass++;
   endtask

   task automatic test_freeze();
      bit          to;
      bit          frz;
      logic        held;
      int          nb;
      logic [5:0]  c;
      logic [31:0] a;
      c = 6'($urandom);
      a = $urandom;
      launch(c, a);
      wait_bits(12, to);
      @(negedge bitclk);
      bc_run = 1'b0;
      repeat (3) @(negedge clk);
      held = data;
      nb = bits.size();
      frz = 1'b1;
      repeat (100) begin
         @(negedge clk);
         if (data !== held || oe !== 1'b1 || active !== 1'b1) frz = 1'b0;
      end
      n_total++;
      if (to !== 1'b0 || !frz || bits.size() != nb)
         $display("FAIL freeze_hold: got data %b/bits %0d want %b/%0d",
                  data, bits.size(), held, nb);
      else n_pass++;
      bc_run = 1'b1;
      wait_done(to);
      n_total++;
      if (to !== 1'b0 || got_token() !== ref_token(c, a))
         $display("FAIL freeze_token: got %h want %h", got_token(),
                  ref_token(c, a));
      else n_pass++;
      n_total++;
      if (n_cmpl !== 1)
         $display("FAIL freeze_cmpl: got %0d pulses want 1", n_cmpl);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit to;
      launch(6'($urandom), $urandom);
      wait_bits(25, to);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_total++;
      if (to !== 1'b0 || {data, oe, active, complete} !== 4'b1000)
         $display("FAIL rstmid_async: got %b want 1000",
                  {data, oe, active, complete});
      else n_pass++;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (400) @(negedge clk);
      n_total++;
      if (n_cmpl !== 0 || active !== 1'b0)
         $display("FAIL rstmid_cmpl: got %0d pulses active %b want 0/0",
                  n_cmpl, active);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_known();
      test_random();
      test_restart_ignored();
      test_abort();
      test_abort_start_idle();
      test_freeze();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
